// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect/halt control.
// Define FETCH_PERF_CNT_EN to add the fetch_count/stall_count performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'd4096,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fetch_fault_d,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;
  logic        r_fault_d;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_out_of_range;

  assign w_pc_plus4     = r_pc_f + 32'd4;
  assign w_redirect_pc  = {redirect_target[31:2], 2'b00};
  assign w_out_of_range = (r_pc_f >= IMEM_BYTES);

  assign imem_addr     = r_pc_f;
  assign instr_d       = r_instr_d;
  assign pc_d          = r_pc_d;
  assign pc_plus4_d    = r_pc_plus4_d;
  assign valid_d       = r_valid_d;
  assign fetch_fault_d = r_fault_d;
  assign halted        = r_halted;

  // Fetch control FSM with PC and IF/ID register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_pc_f       <= RESET_PC;
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'h0000_0000;
      r_pc_plus4_d <= 32'h0000_0000;
      r_valid_d    <= 1'b0;
      r_fault_d    <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_en) begin
            r_pc_f    <= w_redirect_pc;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
            r_fault_d <= 1'b0;
          end else if (halt_req) begin
            // PC holds so the same instruction is fetched again after resume.
            r_state   <= ST_HALTED;
            r_halted  <= 1'b1;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
            r_fault_d <= 1'b0;
          end else if (stall_f) begin
            r_pc_f <= r_pc_f;
          end else begin
            r_pc_f       <= w_pc_plus4;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            if (w_out_of_range) begin
              r_instr_d <= NOP_INSTR;
              r_valid_d <= 1'b0;
              r_fault_d <= 1'b1;
            end else begin
              r_instr_d <= imem_rdata;
              r_valid_d <= 1'b1;
              r_fault_d <= 1'b0;
            end
          end
        end
        ST_HALTED: begin
          r_instr_d <= NOP_INSTR;
          r_valid_d <= 1'b0;
          r_fault_d <= 1'b0;
          if (redirect_en) begin
            r_pc_f <= w_redirect_pc;
          end else begin
            r_pc_f <= r_pc_f;
          end
          // A simultaneous halt request keeps the stage parked.
          if (resume && !halt_req) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end else begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_run;
  logic        w_fetch_valid;

  assign w_run         = (r_state == ST_RUN);
  assign w_fetch_valid = w_run && !redirect_en && !halt_req && !stall_f && !w_out_of_range;
  assign fetch_count   = r_fetch_count;
  assign stall_count   = r_stall_count;

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_fetch_valid) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end else begin
        r_fetch_count <= r_fetch_count;
      end
      if (w_run && stall_f && !redirect_en) begin
        r_stall_count <= r_stall_count + 32'd1;
      end else begin
        r_stall_count <= r_stall_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: startup/wrap sequence, vector table with scoreboard, perf counters.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall_f, redirect_en, halt_req, resume;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fetch_fault_d, halted;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
  logic        w_valid, w_fault, w_halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, w_fcnt, w_scnt;
`endif

  logic [31:0] mem [0:1023];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[11:2]];
  assign w_rdata    = mem[w_addr[11:2]];

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(32'd4096), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .redirect_en(redirect_en),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_fault_d(fetch_fault_d), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_BYTES(32'd4096), .NOP_INSTR(32'h0000_0013)) dut_wrap (
    .clk(clk), .rst(rst), .stall_f(stall_f), .redirect_en(redirect_en),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .imem_addr(w_addr), .imem_rdata(w_rdata), .instr_d(w_instr), .pc_d(w_pc),
    .pc_plus4_d(w_pc4), .valid_d(w_valid), .fetch_fault_d(w_fault), .halted(w_halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(w_fcnt), .stall_count(w_scnt)
`endif
  );

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] tgt;
    logic        halt, res;
    logic [31:0] e_instr, e_pc, e_pc4;
    logic        e_valid, e_fault, e_halted;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [0:26];
  vec_t sb [$];

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] t,
                              input logic h, input logic rs, input logic [31:0] ei, input logic [31:0] ep,
                              input logic [31:0] ep4, input logic ev, input logic ef, input logic eh,
                              input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.tgt = t; v.halt = h; v.res = rs;
    v.e_instr = ei; v.e_pc = ep; v.e_pc4 = ep4; v.e_valid = ev; v.e_fault = ef;
    v.e_halted = eh; v.e_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] t,
                       input logic h, input logic rs);
    @(negedge clk);
    rst = r; stall_f = s; redirect_en = rd; redirect_target = t; halt_req = h; resume = rs;
  endtask

  task automatic step(input int idx, input vec_t v);
    vec_t e;
    drive(v.rst, v.stall, v.redir, v.tgt, v.halt, v.res);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d instr_d", idx), instr_d, e.e_instr);
    chk($sformatf("v%0d pc_d", idx), pc_d, e.e_pc);
    chk($sformatf("v%0d pc_plus4_d", idx), pc_plus4_d, e.e_pc4);
    chk($sformatf("v%0d valid_d", idx), {31'd0, valid_d}, {31'd0, e.e_valid});
    chk($sformatf("v%0d fetch_fault_d", idx), {31'd0, fetch_fault_d}, {31'd0, e.e_fault});
    chk($sformatf("v%0d halted", idx), {31'd0, halted}, {31'd0, e.e_halted});
    chk($sformatf("v%0d imem_addr", idx), imem_addr, e.e_addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = (32'(i) << 20) | 32'h0000_0093;
    mem[0] = 32'h7ff00313;
    mem[1] = 32'h80000393;
    mem[2] = 32'h007304b3;

    //            rst  stl  rdr  tgt           hlt  res  instr         pc_d          pc4           v    f    h    addr
    vecs[0]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h80000393,32'h4,        32'h8,        1'b1,1'b0,1'b0,32'h8);
    vecs[1]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h80000393,32'h4,        32'h8,        1'b1,1'b0,1'b0,32'h8);
    vecs[2]  = mk(1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,32'h80000393,32'h4,        32'h8,        1'b1,1'b0,1'b0,32'h8);
    vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h007304b3,32'h8,        32'hC,        1'b1,1'b0,1'b0,32'hC);
    vecs[4]  = mk(1'b0,1'b1,1'b1,32'h6,        1'b0,1'b0,32'h00000013,32'h8,        32'hC,        1'b0,1'b0,1'b0,32'h4);
    vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h80000393,32'h4,        32'h8,        1'b1,1'b0,1'b0,32'h8);
    vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h00000013,32'h4,        32'h8,        1'b0,1'b0,1'b1,32'h8);
    vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h00000013,32'h4,        32'h8,        1'b0,1'b0,1'b1,32'h8);
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = vecs[7];
    vecs[11] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h00000013,32'h4,        32'h8,        1'b0,1'b0,1'b0,32'h8);
    vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h007304b3,32'h8,        32'hC,        1'b1,1'b0,1'b0,32'hC);
    vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h00000013,32'h8,        32'hC,        1'b0,1'b0,1'b1,32'hC);
    vecs[14] = mk(1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1,32'h00000013,32'h8,        32'hC,        1'b0,1'b0,1'b1,32'hC);
    vecs[15] = mk(1'b0,1'b0,1'b1,32'h100,      1'b0,1'b0,32'h00000013,32'h8,        32'hC,        1'b0,1'b0,1'b1,32'h100);
    vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,32'h00000013,32'h8,        32'hC,        1'b0,1'b0,1'b0,32'h100);
    vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h04000093,32'h100,      32'h104,      1'b1,1'b0,1'b0,32'h104);
    vecs[18] = mk(1'b0,1'b0,1'b1,32'hFFE,      1'b0,1'b0,32'h00000013,32'h100,      32'h104,      1'b0,1'b0,1'b0,32'hFFC);
    vecs[19] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h3FF00093,32'hFFC,      32'h1000,     1'b1,1'b0,1'b0,32'h1000);
    vecs[20] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h00000013,32'h1000,     32'h1004,     1'b0,1'b1,1'b0,32'h1004);
    vecs[21] = mk(1'b0,1'b0,1'b1,32'h8,        1'b1,1'b0,32'h00000013,32'h1000,     32'h1004,     1'b0,1'b0,1'b0,32'h8);
    vecs[22] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h007304b3,32'h8,        32'hC,        1'b1,1'b0,1'b0,32'hC);
    vecs[23] = mk(1'b0,1'b0,1'b1,32'h8,        1'b0,1'b0,32'h00000013,32'h8,        32'hC,        1'b0,1'b0,1'b0,32'h8);
    vecs[24] = mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h00000013,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0);
    vecs[25] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h00000013,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0);
    vecs[26] = mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,32'h7ff00313,32'h0,        32'h4,        1'b1,1'b0,1'b0,32'h4);

    // Reset, BOOT cycle and first two captures on both the normal and the wrapping instance.
    rst = 1'b1; stall_f = 1'b0; redirect_en = 1'b0; redirect_target = 32'h0; halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst instr_d", instr_d, 32'h00000013);
    chk("rst pc_d", pc_d, 32'h0);
    chk("rst pc_plus4_d", pc_plus4_d, 32'h0);
    chk("rst valid_d", {31'd0, valid_d}, 32'd0);
    chk("rst fault", {31'd0, fetch_fault_d}, 32'd0);
    chk("rst halted", {31'd0, halted}, 32'd0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst wrap imem_addr", w_addr, 32'hFFFFFFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("boot valid_d", {31'd0, valid_d}, 32'd0);
    chk("boot instr_d", instr_d, 32'h00000013);
    chk("boot imem_addr", imem_addr, 32'h0);
    chk("boot wrap valid_d", {31'd0, w_valid}, 32'd0);
    @(posedge clk); #1;
    chk("f0 instr_d", instr_d, 32'h7ff00313);
    chk("f0 pc_d", pc_d, 32'h0);
    chk("f0 pc_plus4_d", pc_plus4_d, 32'h4);
    chk("f0 valid_d", {31'd0, valid_d}, 32'd1);
    chk("wrap0 fault", {31'd0, w_fault}, 32'd1);
    chk("wrap0 valid_d", {31'd0, w_valid}, 32'd0);
    chk("wrap0 instr_d", w_instr, 32'h00000013);
    chk("wrap0 pc_d", w_pc, 32'hFFFFFFFC);
    chk("wrap0 pc_plus4_d", w_pc4, 32'h0);
    @(posedge clk); #1;
    chk("f1 instr_d", instr_d, 32'h80000393);
    chk("f1 pc_d", pc_d, 32'h4);
    chk("f1 pc_plus4_d", pc_plus4_d, 32'h8);
    chk("f1 imem_addr", imem_addr, 32'h8);
    chk("wrap1 fault", {31'd0, w_fault}, 32'd0);
    chk("wrap1 valid_d", {31'd0, w_valid}, 32'd1);
    chk("wrap1 pc_d", w_pc, 32'h0);
    chk("wrap1 instr_d", w_instr, 32'h7ff00313);

    for (int i = 0; i < 27; i++) step(i, vecs[i]);

`ifdef FETCH_PERF_CNT_EN
    // Counters: reset, BOOT, three fetches, two stalls, then reset again.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("perf rst fetch_count", fetch_count, 32'd0);
    chk("perf rst stall_count", stall_count, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("perf fetch_count", fetch_count, 32'd3);
    chk("perf stall_count", stall_count, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("perf clr fetch_count", fetch_count, 32'd0);
    chk("perf clr stall_count", stall_count, 32'd0);
`endif

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the RV32I core. Owns the program counter and drives the combinational instruction-memory address. Captures the returned word into the IF/ID pipeline register for the decoder. Handles stall, branch/jump redirect with flush, halt/resume and out-of-range fetch detection.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
IMEM_BYTES, 4096, byte size of instruction memory (1024 words); fetch at PC >= IMEM_BYTES is a fault.
NOP_INSTR, 32'h00000013, bubble encoding (ADDI x0,x0,0).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
stall_f  input  1  hazard unit: hold PC and IF/ID.
redirect_en  input  1  taken branch/jump from EX.
redirect_target  input  32  new PC on redirect.
halt_req  input  1  enter HALTED (e.g. ECALL/EBREAK, debug).
resume  input  1  leave HALTED.
imem_addr  output  32  byte address to instruction memory; equals pc_f combinationally.
imem_rdata  input  32  instruction word, combinational read of imem_addr.
instr_d  output  32  IF/ID instruction.
pc_d  output  32  IF/ID PC of instr_d.
pc_plus4_d  output  32  IF/ID pc_d+4.
valid_d  output  1  instr_d is a real instruction.
fetch_fault_d  output  1  instr_d came from an out-of-range PC.
halted  output  1  state == HALTED.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_fault_d=0, halted=0, state=BOOT.
- States: BOOT, RUN, HALTED.
- BOOT: lasts one cycle after rst deasserts. No capture; valid_d stays 0. Goes to RUN.
- RUN, per-edge priority: redirect_en > halt_req > stall_f > normal.
- Normal fetch: instr_d<=imem_rdata; pc_d<=pc_f; pc_plus4_d<=pc_f+4; valid_d<=1; pc_f<=pc_f+4. Latency: word at PC appears on instr_d one edge after imem_addr=PC.
- Out-of-range: pc_f >= IMEM_BYTES captures instr_d=NOP_INSTR, valid_d=0, fetch_fault_d=1. PC still advances; fault is not sticky. fetch_fault_d=0 on every other capture.
- redirect_en: pc_f<=redirect_target with bits[1:0] forced to 0. IF/ID flushed (instr_d=NOP_INSTR, valid_d=0, fault 0). Overrides stall_f in the same cycle.
- stall_f without redirect: pc_f and all IF/ID outputs hold their values.
- halt_req without redirect: go to HALTED. IF/ID loads a bubble; pc_f holds, so the next instruction is re-fetched on resume.
- HALTED: pc_f holds; IF/ID outputs bubble each cycle; halted=1. redirect_en still updates pc_f, and state stays HALTED. resume moves to RUN on the next edge (halted=0 after that edge); the first fetch occurs in RUN. halt_req and resume together: remain HALTED.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0, and pc_plus4_d wraps the same way.
- rst mid-operation overrides everything on that edge and returns all state to reset values.
- imem_addr is purely combinational from pc_f; no other logic sits on that path.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each edge that loads valid_d=1.
  - stall_count increments on each RUN edge where stall_f=1 and redirect_en=0.
  - Both wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Memory Mem[0]=32'h7ff00313, Mem[4]=32'h80000393, Mem[8]=32'h007304b3, RESET_PC=0; release rst -> one BOOT cycle with valid_d=0; then instr_d sequence 7ff00313/80000393/007304b3 with pc_d 0/4/8, pc_plus4_d 4/8/12, valid_d=1.
- stall_f high for 3 cycles while instr_d=80000393 -> instr_d, pc_d, imem_addr constant for 3 cycles; resumes with 007304b3 at pc_d=8.
- redirect_en with redirect_target=32'h00000006 and stall_f=1 in the same cycle -> next edge: valid_d=0, instr_d=00000013, imem_addr=4; following edge: pc_d=4.
- halt_req at PC=8 -> halted=1, valid_d=0, imem_addr stays 8 for 5 cycles; resume -> halted=0, then instr_d=007304b3 with pc_d=8.
- RESET_PC=32'hFFFFFFFC, IMEM_BYTES=4096 -> first capture has fetch_fault_d=1, valid_d=0, pc_plus4_d=0; next capture has pc_d=0, fetch_fault_d=0, valid_d=1.
- rst asserted mid-run at PC=8 -> next edge: pc_f=0, valid_d=0, halted=0. With FETCH_PERF_CNT_EN: after 3 fetches and 2 stall cycles, fetch_count=3 and stall_count=2; both read 0 after rst.
